// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory bank: size encodings, FSM state
// type and the lane helpers used by dmem_lane_align.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } dmem_state_t;

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] be_mask(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: be_mask = 4'b0001 << lo;
         SZ_HALF: be_mask = lo[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be_mask = 4'b1111;
         default: be_mask = 4'b0000;
      endcase
   endfunction

   // Pick the addressed byte/half out of a word and sign- or zero-extend it.
   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                            input logic [1:0] lo, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: load_ext = {{24{~uns & b[7]}}, b};
         SZ_HALF: load_ext = {{16{~uns & h[15]}}, h};
         SZ_WORD: load_ext = word;
         default: load_ext = 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// write side, extraction and extension on the read side.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rword,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata_sh,
   output logic [31:0] o_rdata
);

   // Replicating the right-aligned store data into every lane means the byte
   // enables alone decide which lanes land, with no variable shifter.
   always_comb begin
      o_be       = be_mask(i_size, i_addr_lo);
      o_wdata_sh = i_wdata;
      case (i_size)
         SZ_BYTE: o_wdata_sh = {4{i_wdata[7:0]}};
         SZ_HALF: o_wdata_sh = {2{i_wdata[15:0]}};
         default: o_wdata_sh = i_wdata;
      endcase
      o_rdata    = load_ext(i_rword, i_size, i_addr_lo, i_uns);
   end

endmodule

// File: rtl/data_mem_bank.sv
// Handshaked word-organised data RAM with byte/half/word access.
// Request accepted in IDLE, array touched in ACCESS, response registered on
// leaving RESP. Optional DMEM_STATS_EN adds load/store counters.
module data_mem_bank
   import dmem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 32
)(
   input  logic              CLK,
   input  logic              reset,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] writeData,
   input  logic [1:0]        memSize,
   input  logic              memUnsigned,
   output logic              ready,
   output logic              valid,
   output logic              err,
`ifdef DMEM_STATS_EN
   output logic [31:0]       loadCount,
   output logic [31:0]       storeCount,
`endif
   output logic [DATA_W-1:0] readData
);

   localparam int IDX_W = $clog2(DEPTH);

   dmem_state_t       r_state, w_next;
   logic              r_op_rd, r_op_wr, r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rword, r_rdata;
   logic [1:0]        r_size;
   logic              r_valid, r_err;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_fault;
   logic [IDX_W-1:0]  w_idx;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata_sh, w_rdata;

   assign w_idx   = r_addr[IDX_W+1:2];
   assign w_fault = (r_op_rd & r_op_wr)
                  | (r_size == SZ_RSVD)
                  | ((r_size == SZ_HALF) & r_addr[0])
                  | ((r_size == SZ_WORD) & (|r_addr[1:0]))
                  | (|r_addr[ADDR_W-1:IDX_W+2]);

   dmem_lane_align u_align (
      .i_addr_lo  (r_addr[1:0]),
      .i_size     (r_size),
      .i_uns      (r_uns),
      .i_wdata    (r_wdata),
      .i_rword    (r_rword),
      .o_be       (w_be),
      .o_wdata_sh (w_wdata_sh),
      .o_rdata    (w_rdata)
   );

   // State register.
   always_ff @(posedge CLK) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state: fixed three-step walk once a request is taken.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (memRead | memWrite) w_next = ST_ACCESS;
         ST_ACCESS: w_next = ST_RESP;
         ST_RESP:   w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   assign ready = (r_state == ST_IDLE);

   // Capture the request; inputs are ignored outside IDLE.
   always_ff @(posedge CLK) begin
      if (!reset && r_state == ST_IDLE && (memRead | memWrite)) begin
         r_op_rd <= memRead;
         r_op_wr <= memWrite;
         r_addr  <= address;
         r_wdata <= writeData;
         r_size  <= memSize;
         r_uns   <= memUnsigned;
      end
   end

   // Array access; reset suppresses a pending store, contents are never cleared.
   always_ff @(posedge CLK) begin
      if (!reset && r_state == ST_ACCESS && !w_fault) begin
         if (r_op_wr) begin
            for (int l = 0; l < 4; l++)
               if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata_sh[8*l +: 8];
         end
         if (r_op_rd) r_rword <= r_mem[w_idx];
      end
   end

   // Registered response; stores leave readData untouched, faults zero it.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_valid <= (r_state == ST_RESP);
         r_err   <= (r_state == ST_RESP) & w_fault;
         if (r_state == ST_RESP) begin
            if (w_fault)      r_rdata <= '0;
            else if (r_op_rd) r_rdata <= w_rdata;
         end
      end
   end

   assign valid    = r_valid;
   assign err      = r_err;
   assign readData = r_rdata;

`ifdef DMEM_STATS_EN
   logic [31:0] r_load_cnt, r_store_cnt;

   // Count only requests that actually reached the array.
   always_ff @(posedge CLK) begin
      if (reset) begin
         r_load_cnt  <= '0;
         r_store_cnt <= '0;
      end else if (r_state == ST_ACCESS && !w_fault) begin
         if (r_op_rd) r_load_cnt  <= r_load_cnt + 32'd1;
         if (r_op_wr) r_store_cnt <= r_store_cnt + 32'd1;
      end
   end

   assign loadCount  = r_load_cnt;
   assign storeCount = r_store_cnt;
`endif

endmodule
